// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register with CCR, flush/back-pressure, forwarding and memory watchdog
module ex_mem_stage_reg #(
  parameter int WATCHDOG_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_result,
  input  logic [2:0]  ccr_in,
  input  logic        flag_en,
  input  logic [15:0] store_data,
  input  logic [2:0]  dst_addr,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        flush,
  input  logic        mem_busy,
  input  logic        ccr_restore_en,
  input  logic [2:0]  ccr_restore,
  output logic        valid_q,
  output logic        reg_write_q,
  output logic        mem_read_q,
  output logic        mem_write_q,
  output logic [15:0] result_q,
  output logic [15:0] store_data_q,
  output logic [2:0]  dst_addr_q,
  output logic [2:0]  ccr,
  output logic        stall_out,
  output logic        fwd_en,
  output logic [2:0]  fwd_addr,
  output logic [15:0] fwd_data,
  output logic        load_use,
  output logic        hold_err
);
  localparam logic [3:0] WD_MAX = 4'(WATCHDOG_MAX);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_nx;
  logic [3:0] wd_cnt, wd_nx;
  logic cap, live;
  assign cap = ~mem_busy;
  // a flush seen during a hold turns the release capture into a bubble
  assign live = valid_in & ~flush & (state == IDLE);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? ((mem_busy & flush) ? PEND : IDLE) : (mem_busy ? PEND : IDLE);
    wd_nx = 4'd0;
    wd_nx = mem_busy ? ((wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + 4'd1) : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      dst_addr_q   <= '0;
      ccr          <= '0;
      wd_cnt       <= '0;
      hold_err     <= 1'b0;
    end else begin
      state  <= state_nx;
      wd_cnt <= wd_nx;
      if (cap) begin
        valid_q      <= live;
        reg_write_q  <= live & reg_write;
        mem_read_q   <= live & mem_read;
        mem_write_q  <= live & mem_write;
        result_q     <= alu_result;
        store_data_q <= store_data;
        dst_addr_q   <= dst_addr;
      end
      if (ccr_restore_en) ccr <= ccr_restore;
      else if (cap & live & flag_en) ccr <= ccr_in;
      if (mem_busy && wd_nx == WD_MAX) hold_err <= 1'b1;
    end
  end
  assign stall_out = mem_busy;
  assign fwd_en    = valid_q & reg_write_q & ~mem_read_q;
  assign fwd_addr  = dst_addr_q;
  assign fwd_data  = result_q;
  assign load_use  = valid_q & mem_read_q;
endmodule

// File: doc/ex_mem_stage_reg.md
# ex_mem_stage_reg

EX/MEM pipeline register of the five-stage processor. It captures the execute-stage ALU result, condition flags and control bits for the memory stage, and holds the architectural condition-code register (CCR: bit0 zero, bit1 negative, bit2 overflow). It supports memory-stage back-pressure, branch flush and flag restore. It also drives a forwarding port back to execute and a stuck-memory watchdog.

## Interface
- `WATCHDOG_MAX`, default 15: consecutive `mem_busy` cycles that set `hold_err`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  execute stage presents a real instruction.
- `alu_result`  in  16  ALU output.
- `ccr_in`  in  3  flags computed by the ALU this cycle.
- `flag_en`  in  1  instruction updates the CCR (ADD/NOT).
- `store_data`  in  16  register value for memory write.
- `dst_addr`  in  3  destination register index.
- `reg_write`, `mem_read`, `mem_write`  in  1 each  control bits.
- `flush`  in  1  kill the instruction currently presented by execute.
- `mem_busy`  in  1  memory stage cannot accept a new instruction.
- `ccr_restore_en`  in  1  load the CCR from `ccr_restore` (RTI).
- `ccr_restore`  in  3  restore value.
- `valid_q`, `reg_write_q`, `mem_read_q`, `mem_write_q`  out  1 each  registered slot.
- `result_q`, `store_data_q`  out  16  registered slot.
- `dst_addr_q`  out  3  registered slot.
- `ccr`  out  3  architectural flags.
- `stall_out`  out  1  upstream must hold its outputs; equal to `mem_busy`, combinational.
- `fwd_en`  out  1  combinational `valid_q & reg_write_q & ~mem_read_q`.
- `fwd_addr`  out  3  equal to `dst_addr_q`.
- `fwd_data`  out  16  equal to `result_q`.
- `load_use`  out  1  combinational `valid_q & mem_read_q`; execute must stall one cycle on a register match.
- `hold_err`  out  1  sticky watchdog error.

## Operation
- Reset: every output register is 0, including `ccr`, `hold_err`, `pending_flush` and the watchdog counter.
- Capture condition is `~mem_busy`. On capture, all slot fields load from the inputs.
  - `valid_q` loads `valid_in & ~flush & ~pending_flush`.
  - A flushed or bubble capture forces `reg_write_q`, `mem_read_q` and `mem_write_q` to 0.
  - The data fields still load; their value is don't-care.
- Hold (`mem_busy`=1): the slot is unchanged.
  - `flush` asserted during a hold sets `pending_flush`.
  - `pending_flush` clears on the next capture, and that capture is a bubble.
- CCR update:
  - `ccr` loads `ccr_in` on a capture with `valid_in & flag_en & ~flush & ~pending_flush`.
  - `ccr_restore_en` loads `ccr_restore` every cycle it is asserted, regardless of `mem_busy`.
  - When both occur in the same cycle, restore wins.
  - Otherwise `ccr` holds.
- Watchdog:
  - A 4-bit counter increments while `mem_busy`=1, saturates at `WATCHDOG_MAX`, and clears to 0 when `mem_busy`=0.
  - `hold_err` sets when the counter reaches `WATCHDOG_MAX` with `mem_busy` still 1, so the counter equals `WATCHDOG_MAX` in the same cycle `hold_err` first reads 1.
  - `hold_err` clears only on `rst`.
- State machine, 2 states (`pending_flush`):
  - IDLE→PEND on `mem_busy & flush`.
  - PEND→IDLE on `~mem_busy`.
  - PEND holds under `mem_busy`.
  - `flush` in PEND has no further effect.

## Timing
- Latency of 1 cycle: inputs sampled at edge N appear on the `_q` outputs and on `fwd_*` after edge N.
- `ccr` is visible 1 cycle after the capturing edge; the same timing applies to restore.
- Back-to-back captures every cycle when `mem_busy`=0, giving a throughput of 1 instruction per cycle.
- `stall_out` is combinational from `mem_busy`, with no added cycle.
- `rst` mid-hold or mid-PEND: the next cycle shows all-zero outputs and IDLE; any pending flush is discarded.
- `rst` takes priority over `ccr_restore_en`, capture and the watchdog.

## Test plan
- Reset, then `valid_in`=1, `alu_result`=0x1234, `ccr_in`=3'b000, `flag_en`=1, `reg_write`=1, `dst_addr`=5 → after 1 edge: `valid_q`=1, `result_q`=0x1234, `fwd_en`=1, `fwd_addr`=5, `ccr`=000.
- ADD producing `ccr_in`=3'b110, followed by a store with `flag_en`=0 and `ccr_in`=3'b001 → `ccr` is 110 after the first edge and stays 110 after the second.
- `mem_busy`=1 for 3 cycles with `flush` pulsed in cycle 2, then `mem_busy`=0 with `valid_in`=1 → the slot is held for 3 cycles, the release capture gives `valid_q`=0, and the following capture is valid.
- Same cycle: `ccr_restore_en`=1, `ccr_restore`=3'b101, plus a capture with `flag_en`=1 and `ccr_in`=3'b010 → `ccr`=101.
- `mem_read`=1, `dst_addr`=2 captured → `load_use`=1 and `fwd_en`=0. A flushed `mem_write` capture → `mem_write_q`=0.
- `mem_busy` held for 16 cycles → `hold_err`=1 and the counter equals `WATCHDOG_MAX` in the same cycle. Release `mem_busy` → `hold_err` stays 1. Assert `rst` → `hold_err`=0.
